// File: rtl/peak_record_reader.sv
// peak_record_reader: bus master for the FFT accelerator's byte window. It checks the
// signature once after reset, then polls and reassembles peak records, emitting only new ones.
`default_nettype none

module peak_record_reader #(
  parameter int POLL_GAP  = 64,
  parameter int CHECK_SIG = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic [7:0]     address,
  output logic           chipselect,
  output logic           write,
  output logic [7:0]     writedata,
  input  logic [7:0]     readdata,
  output logic           rec_valid,
  input  logic           rec_ready,
  output logic [31:0]    rec_counter,
  output logic [47:0]    rec_freq,
  output logic [143:0]   rec_ampl,
  output logic           sig_ok,
  output logic           sig_err
);

  localparam int               GAP_W        = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(POLL_GAP - 1);
  localparam logic [63:0]      SIG_EXPECTED = 64'h2A35_5447_0719_3060;
  localparam logic [5:0]       LAST_REC_IDX = 6'd32;
  localparam logic [7:0]       PARK_ADDR    = 8'hFF;

  typedef enum logic [3:0] {
    ST_SIG_WAIT  = 4'd0,
    ST_SIG_READ  = 4'd1,
    ST_SIG_LAST  = 4'd2,
    ST_SIG_CHECK = 4'd3,
    ST_ERROR     = 4'd4,
    ST_PARK      = 4'd5,
    ST_PRIME     = 4'd6,
    ST_READ      = 4'd7,
    ST_LAST      = 4'd8,
    ST_COMPARE   = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [63:0]        sig_q, sig_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [47:0]        freq_q, freq_d;
  logic [143:0]       ampl_q, ampl_d;
  logic [31:0]        last_cnt_q, last_cnt_d;
  logic               have_last_q, have_last_d;
  logic               rec_valid_q, rec_valid_d;
  logic [31:0]        rec_counter_q, rec_counter_d;
  logic [47:0]        rec_freq_q, rec_freq_d;
  logic [143:0]       rec_ampl_q, rec_ampl_d;
  logic               sig_ok_q, sig_ok_d;
  logic               sig_err_q, sig_err_d;

  logic [7:0]         bus_addr;
  logic               sig_cap;
  logic               rec_cap;
  logic [5:0]         cap_idx;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    sig_d         = sig_q;
    cnt_d         = cnt_q;
    freq_d        = freq_q;
    ampl_d        = ampl_q;
    last_cnt_d    = last_cnt_q;
    have_last_d   = have_last_q;
    rec_valid_d   = rec_valid_q;
    rec_counter_d = rec_counter_q;
    rec_freq_d    = rec_freq_q;
    rec_ampl_d    = rec_ampl_q;
    sig_ok_d      = sig_ok_q;
    sig_err_d     = sig_err_q;
    bus_addr      = PARK_ADDR;
    sig_cap       = 1'b0;
    rec_cap       = 1'b0;
    cap_idx       = 6'd0;

    if (rec_valid_q && rec_ready) begin
      rec_valid_d = 1'b0;
    end

    case (state_q)
      ST_SIG_WAIT: begin
        idx_d   = 6'd0;
        state_d = ST_SIG_READ;
      end
      ST_SIG_READ: begin
        bus_addr = {5'b11111, idx_q[2:0]};
        sig_cap  = (idx_q != 6'd0);
        cap_idx  = idx_q - 6'd1;
        if (idx_q[2:0] == 3'd7) begin
          state_d = ST_SIG_LAST;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_SIG_LAST: begin
        sig_cap = 1'b1;
        cap_idx = 6'd7;
        state_d = ST_SIG_CHECK;
      end
      ST_SIG_CHECK: begin
        if (sig_q == SIG_EXPECTED) begin
          sig_ok_d = 1'b1;
          state_d  = ST_PARK;
        end else begin
          sig_err_d = 1'b1;
          state_d   = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      ST_PARK: begin
        // A pending record blocks the next poll so it can never be overwritten.
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (enable && !rec_valid_q) begin
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        // Byte 0 is presented twice; the first read predates the slave freeze.
        bus_addr = 8'h00;
        idx_d    = 6'd0;
        state_d  = ST_READ;
      end
      ST_READ: begin
        bus_addr = {2'b00, idx_q};
        rec_cap  = (idx_q != 6'd0);
        cap_idx  = idx_q - 6'd1;
        if (idx_q == LAST_REC_IDX) begin
          state_d = ST_LAST;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_LAST: begin
        rec_cap = 1'b1;
        cap_idx = LAST_REC_IDX;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (!have_last_q || (cnt_q != last_cnt_q)) begin
          rec_counter_d = cnt_q;
          rec_freq_d    = freq_q;
          rec_ampl_d    = ampl_q;
          rec_valid_d   = 1'b1;
          last_cnt_d    = cnt_q;
          have_last_d   = 1'b1;
        end
        gap_d   = '0;
        state_d = ST_PARK;
      end
      default: begin
        state_d = ST_PARK;
      end
    endcase

    if (sig_cap) begin
      for (int k = 0; k < 8; k++) begin
        if (cap_idx[2:0] == 3'(k)) begin
          sig_d[63-8*k -: 8] = readdata;
        end
      end
    end

    // Bytes 13,17,21,25,29 are padding and fall through every match below.
    if (rec_cap) begin
      for (int k = 0; k < 4; k++) begin
        if (cap_idx == 6'(k)) begin
          cnt_d[31-8*k -: 8] = readdata;
        end
      end
      for (int k = 0; k < 6; k++) begin
        if (cap_idx == 6'(4 + k)) begin
          freq_d[8*k +: 8] = readdata;
        end
      end
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (cap_idx == 6'(10 + 4*i + j)) begin
            ampl_d[24*i+23-8*j -: 8] = readdata;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= (CHECK_SIG != 0) ? ST_SIG_WAIT : ST_PARK;
      idx_q         <= 6'd0;
      gap_q         <= '0;
      sig_q         <= 64'd0;
      cnt_q         <= 32'd0;
      freq_q        <= 48'd0;
      ampl_q        <= 144'd0;
      last_cnt_q    <= 32'd0;
      have_last_q   <= 1'b0;
      rec_valid_q   <= 1'b0;
      rec_counter_q <= 32'd0;
      rec_freq_q    <= 48'd0;
      rec_ampl_q    <= 144'd0;
      sig_ok_q      <= (CHECK_SIG == 0);
      sig_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      sig_q         <= sig_d;
      cnt_q         <= cnt_d;
      freq_q        <= freq_d;
      ampl_q        <= ampl_d;
      last_cnt_q    <= last_cnt_d;
      have_last_q   <= have_last_d;
      rec_valid_q   <= rec_valid_d;
      rec_counter_q <= rec_counter_d;
      rec_freq_q    <= rec_freq_d;
      rec_ampl_q    <= rec_ampl_d;
      sig_ok_q      <= sig_ok_d;
      sig_err_q     <= sig_err_d;
    end
  end

  assign address     = bus_addr;
  assign chipselect  = (bus_addr != PARK_ADDR);
  assign write       = 1'b0;
  assign writedata   = 8'h00;
  assign rec_valid   = rec_valid_q;
  assign rec_counter = rec_counter_q;
  assign rec_freq    = rec_freq_q;
  assign rec_ampl    = rec_ampl_q;
  assign sig_ok      = sig_ok_q;
  assign sig_err     = sig_err_q;

endmodule

`default_nettype wire

// File: tb/tb_peak_record_reader.sv
// tb_peak_record_reader: directed bench with a freezing byte-window slave model
// for signature check, record assembly, suppression, backpressure and reset.
`timescale 1ns/1ps
`default_nettype none

module tb_peak_record_reader;

  localparam int POLL_GAP = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         rec_ready;
  logic [7:0]   address;
  logic         chipselect;
  logic         write;
  logic [7:0]   writedata;
  logic [7:0]   readdata;
  logic         rec_valid;
  logic [31:0]  rec_counter;
  logic [47:0]  rec_freq;
  logic [143:0] rec_ampl;
  logic         sig_ok;
  logic         sig_err;

  logic [7:0]   live [256];
  logic [7:0]   snap [256];
  logic         frozen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peak_record_reader #(
    .POLL_GAP  (POLL_GAP),
    .CHECK_SIG (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_counter (rec_counter),
    .rec_freq    (rec_freq),
    .rec_ampl    (rec_ampl),
    .sig_ok      (sig_ok),
    .sig_err     (sig_err)
  );

  // Slave: registered read of a snapshot that stops refreshing one cycle after address < 33.
  always @(posedge clk) begin
    readdata <= snap[address];
    if (!frozen) snap <= live;
    frozen <= (address < 8'd33);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rec(input logic [31:0] cnt, input logic [7:0] fb, input logic [7:0] ab);
    for (int k = 0; k < 4; k++) live[k] = cnt[31-8*k -: 8];
    for (int i = 0; i < 6; i++) live[4+i] = fb + 8'(i);
    for (int i = 0; i < 6; i++) begin
      live[10+4*i] = ab + 8'(i);
      live[11+4*i] = ab + 8'h10 + 8'(i);
      live[12+4*i] = 8'(i);
      live[13+4*i] = 8'hEE;
    end
  endtask

  task automatic wait_addr(input logic [7:0] a, input int bound, output int n);
    n = 0;
    while (address !== a && n < bound) begin
      tick();
      n++;
    end
    if (address !== a) n = -1;
  endtask

  task automatic wait_rec(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (rec_valid !== 1'b1 && n < bound);
    if (rec_valid !== 1'b1) n = -1;
  endtask

  initial begin
    logic [63:0] sigv;
    int          n;
    int          bad;
    int          pulses;
    logic        prev;
    logic [31:0] got;

    sigv = 64'h2A35_5447_0719_3060;
    for (int a = 0; a < 256; a++) live[a] = 8'h00;
    for (int k = 0; k < 8; k++) live[248+k] = sigv[63-8*k -: 8];
    set_rec(32'h0000_012C, 8'h01, 8'h10);
    reset     = 1'b1;
    enable    = 1'b1;
    rec_ready = 1'b0;
    repeat (4) tick();

    chk("rst_address",    192'(address),     192'(8'hFF));
    chk("rst_chipselect", 192'(chipselect),  192'(1'b0));
    chk("rst_rec_valid",  192'(rec_valid),   192'(1'b0));
    chk("rst_sig_ok",     192'(sig_ok),      192'(1'b0));
    chk("rst_sig_err",    192'(sig_err),     192'(1'b0));
    chk("rst_counter",    192'(rec_counter), 192'(32'h0));
    chk("rst_freq",       192'(rec_freq),    192'(48'h0));
    chk("rst_ampl",       192'(rec_ampl),    192'(144'h0));
    chk("write_const",    192'(write),       192'(1'b0));
    chk("wdata_const",    192'(writedata),   192'(8'h00));

    // Signature window 248..255, then SIG_LAST, SIG_CHECK, PARK.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("sig_addr", 192'(address), 192'(8'd248 + 8'(k)));
    end
    tick();
    chk("sig_last_addr", 192'(address), 192'(8'hFF));
    chk("sig_ok_early",  192'(sig_ok),  192'(1'b0));
    tick();
    tick();
    chk("sig_ok",        192'(sig_ok),  192'(1'b1));
    chk("sig_err_clear", 192'(sig_err), 192'(1'b0));

    wait_addr(8'h00, 200, n);
    chk("first_prime_gap", 192'(n), 192'(POLL_GAP));
    chk("prime_cs",        192'(chipselect), 192'(1'b1));
    tick();
    chk("prime_repeat_addr0", 192'(address), 192'(8'h00));
    wait_rec(60, n);
    chk("rec_latency_36", 192'(n + 1), 192'(36));
    chk("recA_counter",   192'(rec_counter), 192'(32'h0000_012C));
    chk("recA_freq",      192'(rec_freq),    192'(48'h0605_0403_0201));
    chk("recA_ampl0",     192'(rec_ampl[23:0]), 192'(24'h102000));
    chk("recA_ampl",      192'(rec_ampl), 192'(144'h152505_142404_132303_122202_112101_102000));

    // Backpressure: everything holds and no poll starts.
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (rec_valid !== 1'b1 || rec_counter !== 32'h0000_012C ||
          rec_freq !== 48'h0605_0403_0201 || address !== 8'hFF) bad++;
    end
    chk("bp_stable", 192'(bad), 192'(0));
    rec_ready = 1'b1;
    tick();
    chk("bp_transfer", 192'(rec_valid), 192'(1'b0));
    wait_addr(8'h00, 10, n);
    chk("prime_after_release", 192'(n), 192'(1));

    // Duplicate poll followed by a changed counter.
    wait_addr(8'hFF, 60, n);
    chk("poll_read_length", 192'(n), 192'(34));
    live[3] = 8'h2D;
    pulses = 0;
    prev   = rec_valid;
    got    = 32'h0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rec_valid === 1'b1 && prev !== 1'b1) begin
        pulses++;
        got = rec_counter;
      end
      prev = rec_valid;
    end
    chk("dup_pulses",  192'(pulses), 192'(1));
    chk("dup_counter", 192'(got), 192'(32'h0000_012D));

    // Counter wrap FFFFFFFF -> 0 is a change.
    set_rec(32'hFFFF_FFFF, 8'h01, 8'h10);
    wait_rec(300, n);
    chk("wrap_hi_seen", 192'(n > 0), 192'(1'b1));
    chk("wrap_hi",      192'(rec_counter), 192'(32'hFFFF_FFFF));
    set_rec(32'h0000_0000, 8'h01, 8'h10);
    wait_rec(300, n);
    chk("wrap_zero_seen", 192'(n > 0), 192'(1'b1));
    chk("wrap_zero",      192'(rec_counter), 192'(32'h0));

    // enable dropped during PRIME: the poll still completes, then polling stops.
    set_rec(32'h0000_0777, 8'h01, 8'h10);
    wait_addr(8'h00, 200, n);
    enable = 1'b0;
    wait_rec(60, n);
    chk("en_mid_poll_latency", 192'(n), 192'(36));
    chk("en_mid_poll_counter", 192'(rec_counter), 192'(32'h0000_0777));
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (address !== 8'hFF) bad++;
    end
    chk("disabled_idle", 192'(bad), 192'(0));

    // Snapshot coherence: live data switches from B to C in the PRIME cycle.
    set_rec(32'hAA00_0500, 8'h90, 8'h30);
    enable = 1'b1;
    wait_addr(8'h00, 200, n);
    chk("prime_on_enable", 192'(n), 192'(1));
    set_rec(32'h1122_3344, 8'h40, 8'h70);
    wait_rec(60, n);
    chk("coh_latency", 192'(n), 192'(36));
    chk("coh_counter", 192'(rec_counter), 192'(32'h1122_3344));
    chk("coh_freq",    192'(rec_freq),    192'(48'h4544_4342_4140));
    chk("coh_ampl",    192'(rec_ampl), 192'(144'h758505_748404_738303_728202_718101_708000));

    // Reset in the middle of a read.
    set_rec(32'h0000_0999, 8'h01, 8'h10);
    wait_addr(8'h00, 200, n);
    wait_addr(8'h0F, 40, n);
    chk("reach_addr15", 192'(n), 192'(16));
    reset = 1'b1;
    tick();
    chk("midrst_address",   192'(address),     192'(8'hFF));
    chk("midrst_rec_valid", 192'(rec_valid),   192'(1'b0));
    chk("midrst_sig_ok",    192'(sig_ok),      192'(1'b0));
    chk("midrst_counter",   192'(rec_counter), 192'(32'h0));
    reset = 1'b0;
    tick();
    chk("sig_rerun_addr", 192'(address), 192'(8'd248));
    repeat (10) tick();
    chk("sig_rerun_ok", 192'(sig_ok), 192'(1'b1));

    // Signature mismatch at byte 252.
    reset = 1'b1;
    live[252] = 8'h08;
    repeat (3) tick();
    reset = 1'b0;
    repeat (11) tick();
    chk("sigfail_err", 192'(sig_err), 192'(1'b1));
    chk("sigfail_ok",  192'(sig_ok),  192'(1'b0));
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (address !== 8'hFF || chipselect !== 1'b0 || rec_valid !== 1'b0 || sig_err !== 1'b1) bad++;
    end
    chk("sigfail_quiet", 192'(bad), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
